// File: rtl/product_block_accumulator_if.sv
// Handshake bundle between a product source, the block accumulator and its result consumer.
// The master modport is the driving side; the slave modport is the accumulator.
interface product_block_accumulator_if #(
  parameter int unsigned IN_WIDTH  = 36,
  parameter int unsigned ACC_WIDTH = 44,
  parameter int unsigned CNT_WIDTH = 5
);
  logic                 in_valid;
  logic [IN_WIDTH-1:0]  in_data;
  logic                 in_ready;
  logic                 out_valid;
  logic [ACC_WIDTH-1:0] out_data;
  logic                 out_overflow;
  logic                 out_ready;
  logic [CNT_WIDTH-1:0] beat_count;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_overflow,
    output out_ready,
    input  beat_count
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output out_valid,
    output out_data,
    output out_overflow,
    input  out_ready,
    output beat_count
  );
endinterface

// File: rtl/product_block_accumulator.sv
// Sums COUNT accepted product beats into a saturating wide accumulator and hands each
// block sum to a one-entry output register with its own valid/ready handshake.
module product_block_accumulator #(
  parameter int unsigned IN_WIDTH  = 36,
  parameter int unsigned ACC_WIDTH = 44,
  parameter int unsigned COUNT     = 16,
  parameter int unsigned CNT_WIDTH = 5
) (
  input logic                      clock,
  input logic                      reset,
  product_block_accumulator_if.slave bus
);

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StAccum = 1'b1;

  localparam logic [CNT_WIDTH-1:0] LastBeat = CNT_WIDTH'(COUNT - 1);
  localparam logic [CNT_WIDTH-1:0] CntOne   = CNT_WIDTH'(1);

  logic [0:0]           state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;
  logic                 out_valid_q, out_valid_d;
  logic [ACC_WIDTH-1:0] out_data_q, out_data_d;
  logic                 out_ovf_q, out_ovf_d;

  logic [ACC_WIDTH:0]   in_ext;
  logic [ACC_WIDTH:0]   sum_wide;
  logic [ACC_WIDTH-1:0] sat_sum;
  logic                 sat_flag;
  logic                 last_beat;
  logic                 accept;

  assign last_beat = (cnt_q == LastBeat);
  // Only the completing beat needs the output slot, so only it can be stalled.
  assign bus.in_ready = !(last_beat && out_valid_q && !bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  assign bus.out_valid    = out_valid_q;
  assign bus.out_data     = out_data_q;
  assign bus.out_overflow = out_ovf_q;
  assign bus.beat_count   = cnt_q;

  always_comb begin
    in_ext                = '0;
    in_ext[IN_WIDTH-1:0]  = bus.in_data;
    sum_wide              = {1'b0, acc_q} + in_ext;
  end

  // Running value after this beat; a sticky flag keeps the block pinned at all ones.
  always_comb begin
    sat_sum  = sum_wide[ACC_WIDTH-1:0];
    sat_flag = 1'b0;
    if (state_q == StIdle) begin
      sat_sum  = in_ext[ACC_WIDTH-1:0];
      sat_flag = 1'b0;
    end else if (sum_wide[ACC_WIDTH] || ovf_q) begin
      sat_sum  = '1;
      sat_flag = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;

    if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    if (accept) begin
      if (last_beat) begin
        // Completion may coincide with a pop; the new result simply takes the slot.
        out_valid_d = 1'b1;
        out_data_d  = sat_sum;
        out_ovf_d   = sat_flag;
        acc_d       = '0;
        cnt_d       = '0;
        ovf_d       = 1'b0;
        state_d     = StIdle;
      end else begin
        acc_d   = sat_sum;
        cnt_d   = cnt_q + CntOne;
        ovf_d   = sat_flag;
        state_d = StAccum;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

endmodule
